// File: rtl/zigzag_pingpong_buffer.sv
// Two-bank 8x8 block buffer: rows in on one bank, zigzag- or raster-ordered beats out of the other.
// out_data is a combinational read of the draining bank and stays stable while the beat is stalled.
module zigzag_pingpong_buffer #(
    parameter int DATA_W    = 8,
    parameter int OUT_LANES = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [8*DATA_W-1:0]           in_data,
    input  logic                          in_zz,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_LANES*DATA_W-1:0]   out_data,
    output logic                          out_first,
    output logic                          out_last
);

    localparam int BPB    = 64 / OUT_LANES;
    localparam int BEAT_W = $clog2(BPB);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BPB - 1);

    // Standard JPEG zigzag: sequence index -> raster index.
    function automatic logic [5:0] zz_addr(input logic [5:0] s);
        case (s)
            6'd0:  zz_addr = 6'd0;   6'd1:  zz_addr = 6'd1;   6'd2:  zz_addr = 6'd8;   6'd3:  zz_addr = 6'd16;
            6'd4:  zz_addr = 6'd9;   6'd5:  zz_addr = 6'd2;   6'd6:  zz_addr = 6'd3;   6'd7:  zz_addr = 6'd10;
            6'd8:  zz_addr = 6'd17;  6'd9:  zz_addr = 6'd24;  6'd10: zz_addr = 6'd32;  6'd11: zz_addr = 6'd25;
            6'd12: zz_addr = 6'd18;  6'd13: zz_addr = 6'd11;  6'd14: zz_addr = 6'd4;   6'd15: zz_addr = 6'd5;
            6'd16: zz_addr = 6'd12;  6'd17: zz_addr = 6'd19;  6'd18: zz_addr = 6'd26;  6'd19: zz_addr = 6'd33;
            6'd20: zz_addr = 6'd40;  6'd21: zz_addr = 6'd48;  6'd22: zz_addr = 6'd41;  6'd23: zz_addr = 6'd34;
            6'd24: zz_addr = 6'd27;  6'd25: zz_addr = 6'd20;  6'd26: zz_addr = 6'd13;  6'd27: zz_addr = 6'd6;
            6'd28: zz_addr = 6'd7;   6'd29: zz_addr = 6'd14;  6'd30: zz_addr = 6'd21;  6'd31: zz_addr = 6'd28;
            6'd32: zz_addr = 6'd35;  6'd33: zz_addr = 6'd42;  6'd34: zz_addr = 6'd49;  6'd35: zz_addr = 6'd56;
            6'd36: zz_addr = 6'd57;  6'd37: zz_addr = 6'd50;  6'd38: zz_addr = 6'd43;  6'd39: zz_addr = 6'd36;
            6'd40: zz_addr = 6'd29;  6'd41: zz_addr = 6'd22;  6'd42: zz_addr = 6'd15;  6'd43: zz_addr = 6'd23;
            6'd44: zz_addr = 6'd30;  6'd45: zz_addr = 6'd37;  6'd46: zz_addr = 6'd44;  6'd47: zz_addr = 6'd51;
            6'd48: zz_addr = 6'd58;  6'd49: zz_addr = 6'd59;  6'd50: zz_addr = 6'd52;  6'd51: zz_addr = 6'd45;
            6'd52: zz_addr = 6'd38;  6'd53: zz_addr = 6'd31;  6'd54: zz_addr = 6'd39;  6'd55: zz_addr = 6'd46;
            6'd56: zz_addr = 6'd53;  6'd57: zz_addr = 6'd60;  6'd58: zz_addr = 6'd61;  6'd59: zz_addr = 6'd54;
            6'd60: zz_addr = 6'd47;  6'd61: zz_addr = 6'd55;  6'd62: zz_addr = 6'd62;  6'd63: zz_addr = 6'd63;
            default: zz_addr = 6'd0;
        endcase
    endfunction

    logic [DATA_W-1:0] mem_q [0:127];

    logic              wr_bank_q, wr_bank_d;
    logic [2:0]        wr_row_q,  wr_row_d;
    logic              rd_bank_q, rd_bank_d;
    logic [BEAT_W-1:0] rd_beat_q, rd_beat_d;
    logic [1:0]        full_q,    full_d;
    logic [1:0]        mode_q,    mode_d;

    logic in_accept_s;
    logic out_accept_s;
    logic [5:0] seq_s;
    logic [5:0] addr_s;

    // Both handshakes depend only on registered flags, so out_ready never reaches in_ready.
    assign in_ready     = !full_q[wr_bank_q];
    assign out_valid    = full_q[rd_bank_q];
    assign out_first    = out_valid && (rd_beat_q == {BEAT_W{1'b0}});
    assign out_last     = out_valid && (rd_beat_q == LAST_BEAT);
    assign in_accept_s  = in_valid && in_ready;
    assign out_accept_s = out_valid && out_ready;

    // Next-state for fill and drain pointers; set and clear always target different banks.
    always_comb begin
        wr_bank_d = wr_bank_q;
        wr_row_d  = wr_row_q;
        rd_bank_d = rd_bank_q;
        rd_beat_d = rd_beat_q;
        full_d    = full_q;
        mode_d    = mode_q;
        if (in_accept_s) begin
            if (wr_row_q == 3'd0) begin
                mode_d[wr_bank_q] = in_zz;
            end else begin
                mode_d = mode_q;
            end
            if (wr_row_q == 3'd7) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
                wr_row_d          = 3'd0;
            end else begin
                wr_row_d = wr_row_q + 3'd1;
            end
        end else begin
            wr_row_d = wr_row_q;
        end
        if (out_accept_s) begin
            if (rd_beat_q == LAST_BEAT) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
                rd_beat_d         = {BEAT_W{1'b0}};
            end else begin
                rd_beat_d = rd_beat_q + BEAT_W'(1);
            end
        end else begin
            rd_beat_d = rd_beat_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank_q <= 1'b0;
            wr_row_q  <= 3'd0;
            rd_bank_q <= 1'b0;
            rd_beat_q <= {BEAT_W{1'b0}};
            full_q    <= 2'b00;
            mode_q    <= 2'b11;
        end else begin
            wr_bank_q <= wr_bank_d;
            wr_row_q  <= wr_row_d;
            rd_bank_q <= rd_bank_d;
            rd_beat_q <= rd_beat_d;
            full_q    <= full_d;
            mode_q    <= mode_d;
        end
    end

    // Coefficient storage; column 0 sits in the MSBs of the incoming row.
    always_ff @(posedge clk) begin
        if (in_accept_s) begin
            for (int c = 0; c < 8; c++) begin
                mem_q[{wr_bank_q, wr_row_q, 3'(c)}] <= in_data[(7-c)*DATA_W +: DATA_W];
            end
        end
    end

    // Beat assembly: lane 0 carries the lowest sequence index and lands in the MSBs.
    always_comb begin
        out_data = '0;
        seq_s    = 6'd0;
        addr_s   = 6'd0;
        for (int k = 0; k < OUT_LANES; k++) begin
            seq_s  = 6'(int'(rd_beat_q) * OUT_LANES + k);
            addr_s = mode_q[rd_bank_q] ? zz_addr(seq_s) : seq_s;
            out_data[(OUT_LANES-1-k)*DATA_W +: DATA_W] = mem_q[{rd_bank_q, addr_s}];
        end
    end

endmodule

// File: tb/tb_zigzag_pingpong_buffer.sv
// Directed bench for zigzag_pingpong_buffer: reset, ordering modes, ping-pong backpressure,
// random stall soak, and narrow-lane builds.
module tb_zigzag_pingpong_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_zz, out_ready;
    logic [63:0] in_data;
    logic        in_ready, out_valid, out_first, out_last;
    logic [63:0] out_data;

    logic        out_ready1, out_ready2;
    logic        in_ready1, out_valid1, out_first1, out_last1;
    logic        in_ready2, out_valid2, out_first2, out_last2;
    logic [7:0]  out_data1;
    logic [15:0] out_data2;

    zigzag_pingpong_buffer #(.DATA_W(8), .OUT_LANES(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_zz(in_zz), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_first(out_first), .out_last(out_last));

    zigzag_pingpong_buffer #(.DATA_W(8), .OUT_LANES(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .in_zz(in_zz), .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .out_first(out_first1), .out_last(out_last1));

    zigzag_pingpong_buffer #(.DATA_W(8), .OUT_LANES(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .in_zz(in_zz), .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .out_first(out_first2), .out_last(out_last2));

    int total = 0;
    int bad   = 0;
    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt++;

    int zz_tab [64] = '{ 0,  1,  8, 16,  9,  2,  3, 10,
                        17, 24, 32, 25, 18, 11,  4,  5,
                        12, 19, 26, 33, 40, 48, 41, 34,
                        27, 20, 13,  6,  7, 14, 21, 28,
                        35, 42, 49, 56, 57, 50, 43, 36,
                        29, 22, 15, 23, 30, 37, 44, 51,
                        58, 59, 52, 45, 38, 31, 39, 46,
                        53, 60, 61, 54, 47, 55, 62, 63 };

    logic [7:0]  blk [64];
    logic [63:0] exp_data [$];
    logic [1:0]  exp_fl [$];
    int          last_edges [$];
    int          row0_edge;

    task automatic push_expected(input bit zz);
        logic [63:0] w;
        int a;
        for (int b = 0; b < 8; b++) begin
            w = '0;
            for (int k = 0; k < 8; k++) begin
                a = zz ? zz_tab[b*8+k] : b*8+k;
                w[(7-k)*8 +: 8] = blk[a];
            end
            exp_data.push_back(w);
            exp_fl.push_back({b == 0, b == 7});
        end
    endtask

    task automatic send_row(input logic [63:0] d, input logic zz, output int acc_edge);
        bit ok = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_zz    = zz;
        acc_edge = -1;
        for (int c = 0; c < 2000 && !ok; c++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1;
                acc_edge = cyc_cnt + 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL row_accept_timeout: in_ready stayed %b, required 1", in_ready);
        end
    endtask

    task automatic send_rows(input int first, input int count, input bit zz, input bit toggle);
        logic [63:0] row;
        logic z;
        int e;
        for (int r = first; r < first + count; r++) begin
            for (int c = 0; c < 8; c++) row[(7-c)*8 +: 8] = blk[r*8+c];
            z = (r == 0) ? zz : (toggle ? ~zz : zz);
            send_row(row, z, e);
            if (r == 0) row0_edge = e;
        end
    endtask

    task automatic send_block(input bit zz, input bit toggle);
        push_expected(zz);
        send_rows(0, 8, zz, toggle);
    endtask

    task automatic drain(input int n, input bit rnd, input int budget);
        int got = 0;
        int cyc = 0;
        bit stalled = 0;
        logic [63:0] held = '0;
        logic [63:0] ed;
        logic [1:0]  efl;
        while (got < n && cyc < budget) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            cyc++;
            if (stalled) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== held) begin
                    bad++;
                    $display("FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h", out_valid, out_data, held);
                end
            end
            stalled = 0;
            if (out_valid === 1'b1) begin
                if (out_ready) begin
                    total++;
                    if (exp_data.size() == 0) begin
                        bad++;
                        $display("FAIL extra_beat: got data=%h, required no beat", out_data);
                    end else begin
                        ed  = exp_data.pop_front();
                        efl = exp_fl.pop_front();
                        if (out_data !== ed || {out_first, out_last} !== efl) begin
                            bad++;
                            $display("FAIL beat: data=%h first/last=%b%b, required data=%h first/last=%b",
                                     out_data, out_first, out_last, ed, efl);
                        end
                    end
                    if (out_last === 1'b1) last_edges.push_back(cyc_cnt + 1);
                    got++;
                end else begin
                    stalled = 1;
                    held    = out_data;
                end
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        total++;
        if (got != n) begin
            bad++;
            $display("FAIL drain_count: got %0d beats, required %0d", got, n);
        end
    endtask

    task automatic check_queue_empty(input string tag);
        total++;
        if (exp_data.size() != 0) begin
            bad++;
            $display("FAIL %s_leftover: %0d beats never seen, required 0", tag, exp_data.size());
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        total++;
        if ({in_ready, out_valid, out_first, out_last} !== 4'b1000) begin
            bad++;
            $display("FAIL reset_state: rdy/vld/first/last=%b, required 1000", {in_ready, out_valid, out_first, out_last});
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 64; i++) blk[i] = 8'(i + 64);
        send_rows(0, 8, 1'b1, 1'b0);
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL prefill_valid: out_valid=%b, required 1", out_valid);
        end
        send_rows(0, 3, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({in_ready, out_valid, out_first, out_last} !== 4'b1000) begin
            bad++;
            $display("FAIL midfill_reset: rdy/vld/first/last=%b, required 1000", {in_ready, out_valid, out_first, out_last});
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 64; i++) blk[i] = 8'(i + 128);
        push_expected(1'b1);
        send_rows(0, 7, 1'b1, 1'b0);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL early_valid: out_valid=%b before row 7, required 0", out_valid);
        end
        send_rows(7, 1, 1'b1, 1'b0);
        total++;
        if (out_valid !== 1'b1 || out_first !== 1'b1) begin
            bad++;
            $display("FAIL first_latency: valid=%b first=%b, required 1 1", out_valid, out_first);
        end
        drain(8, 1'b0, 50);
        check_queue_empty("reset");
    endtask

    task automatic test_zigzag();
        for (int i = 0; i < 64; i++) blk[i] = 8'(i);
        send_block(1'b1, 1'b0);
        drain(8, 1'b0, 50);
        check_queue_empty("zigzag");
    endtask

    task automatic test_raster();
        for (int i = 0; i < 64; i++) blk[i] = 8'(i);
        send_block(1'b0, 1'b1);
        drain(8, 1'b0, 50);
        check_queue_empty("raster");
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        for (int i = 0; i < 64; i++) blk[i] = 8'(i * 3);
        send_block(1'b1, 1'b0);
        for (int i = 0; i < 64; i++) blk[i] = 8'(255 - i);
        send_block(1'b0, 1'b0);
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL both_full: in_ready=%b out_valid=%b, required 0 1", in_ready, out_valid);
        end
        for (int i = 0; i < 64; i++) blk[i] = 8'(i) ^ 8'h5A;
        last_edges.delete();
        fork
            send_block(1'b1, 1'b0);
            begin
                repeat (3) @(posedge clk);
                #1;
                drain(24, 1'b0, 300);
            end
        join
        total++;
        if (last_edges.size() == 0) begin
            bad++;
            $display("FAIL refill_edge: no last beat seen, required one");
        end else if (row0_edge != last_edges[0] + 1) begin
            bad++;
            $display("FAIL refill_edge: row0 accepted at edge %0d, required %0d", row0_edge, last_edges[0] + 1);
        end
        check_queue_empty("b2b");
    endtask

    task automatic test_random();
        fork
            begin
                for (int b = 0; b < 20; b++) begin
                    for (int i = 0; i < 64; i++) blk[i] = 8'($urandom);
                    send_block(1'($urandom_range(0, 1)), 1'b1);
                end
            end
            drain(160, 1'b1, 20000);
        join
        check_queue_empty("random");
    endtask

    task automatic test_lanes();
        int b1 = 0;
        int b2 = 0;
        logic [15:0] e2;
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        out_ready1 = 1'b1;
        out_ready2 = 1'b1;
        out_ready  = 1'b1;
        for (int i = 0; i < 64; i++) blk[i] = 8'(i) ^ 8'hA5;
        send_rows(0, 8, 1'b1, 1'b0);
        for (int c = 0; c < 200 && (b1 < 64 || b2 < 32); c++) begin
            @(negedge clk);
            if (out_valid1 === 1'b1 && b1 < 64) begin
                total++;
                if (out_data1 !== blk[zz_tab[b1]] || out_first1 !== (b1 == 0) || out_last1 !== (b1 == 63)) begin
                    bad++;
                    $display("FAIL lanes1_beat%0d: data=%h first=%b last=%b, required %h %b %b", b1, out_data1,
                             out_first1, out_last1, blk[zz_tab[b1]], b1 == 0, b1 == 63);
                end
                b1++;
            end
            if (out_valid2 === 1'b1 && b2 < 32) begin
                e2 = {blk[zz_tab[2*b2]], blk[zz_tab[2*b2+1]]};
                total++;
                if (out_data2 !== e2 || out_first2 !== (b2 == 0) || out_last2 !== (b2 == 31)) begin
                    bad++;
                    $display("FAIL lanes2_beat%0d: data=%h first=%b last=%b, required %h %b %b", b2, out_data2,
                             out_first2, out_last2, e2, b2 == 0, b2 == 31);
                end
                b2++;
            end
        end
        total++;
        if (b1 != 64 || b2 != 32) begin
            bad++;
            $display("FAIL lanes_count: got %0d and %0d beats, required 64 and 32", b1, b2);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        rst        = 1'b0;
        in_valid   = 1'b0;
        in_zz      = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        out_ready1 = 1'b0;
        out_ready2 = 1'b0;
        test_reset();
        test_zigzag();
        test_raster();
        test_back_to_back();
        test_random();
        test_lanes();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/zigzag_pingpong_buffer.md
Name: zigzag_pingpong_buffer

Overview:
Sequential successor to the combinational zigzag reorder stage in the JPEG path. It accepts one 8-coefficient row per beat from the quantiser using a valid/ready handshake and assembles each 8x8 block in one of two ping-pong banks. It then streams the block to the entropy coder in zigzag order, or in raster order when bypassed, at OUT_LANES coefficients per beat. One bank fills while the other drains, so back-to-back blocks run without bubbles.

Parameters:
DATA_W, 8, coefficient width in bits
OUT_LANES, 8, coefficients per output beat; legal values 1, 2, 4, 8. Beats per block BPB = 64/OUT_LANES.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  row valid
in_ready  out  1  row accepted when in_valid && in_ready
in_data  in  8*DATA_W  one row; column 0 in MSBs [8*DATA_W-1 -: DATA_W], column 7 in LSBs
in_zz  in  1  1 = zigzag output, 0 = raster output; sampled with row 0 of each block
out_valid  out  1  output beat valid
out_ready  in  1  beat consumed when out_valid && out_ready
out_data  out  OUT_LANES*DATA_W  lane 0 (lowest sequence index) in MSBs
out_first  out  1  high on the first beat of a block
out_last  out  1  high on beat BPB-1 of a block

Behaviour:
- Storage: 2 banks x 64 x DATA_W, addressed by raster index row*8+col. Per-bank state: full flag, stored mode bit.
- Write side: wr_bank (1b), wr_row (3b).
  - in_ready = !full[wr_bank], decoded directly from registered flags.
  - On accept: write 8 coefficients to rows wr_row of wr_bank. If wr_row==0, latch in_zz into mode[wr_bank]. in_zz is ignored on rows 1-7.
  - On accept of wr_row==7: set full[wr_bank], toggle wr_bank, and wrap wr_row to 0.
- Read side: rd_bank (1b), rd_beat (log2(BPB) bits).
  - out_valid = full[rd_bank].
  - Lane k of beat b carries sequence index s = b*OUT_LANES+k.
    - Zigzag mode: raster address = ZZ[s], the standard JPEG table, starting 0,1,8,16,9,2,3,10,17,24,...
    - Raster mode: raster address = s.
  - out_data is a combinational read of the current beat. It is held stable while out_valid && !out_ready.
  - On handshake: rd_beat++. On handshake at rd_beat==BPB-1: clear full[rd_bank], toggle rd_bank, rd_beat=0.
  - out_first = out_valid && rd_beat==0. out_last = out_valid && rd_beat==BPB-1.
- Latency: first beat of a block is valid the cycle after its row 7 is accepted.
- Throughput: 8 rows in per block; BPB beats out per block. Full rate sustained when OUT_LANES==8 and no backpressure.
- Both banks full: in_ready=0 until the drain side frees a bank. A bank freed in cycle t is writable from cycle t+1, with no combinational ready path from out_ready to in_ready.
- Simultaneous set and clear of different banks in one cycle is legal and both take effect. The same bank can never be set and cleared in the same cycle.
- Reset (async, any time, including mid-block): wr_bank=0, wr_row=0, rd_bank=0, rd_beat=0, both full=0, modes=1. Outputs: in_ready=1, out_valid=0, out_first=0, out_last=0. out_data content is don't-care and is not reset. Partial blocks are discarded.
- No arithmetic on data; coefficients pass bit-exact. Any sign interpretation belongs to the consumer.

Test Plan:
- Reset: assert rst mid-fill (after row 3) -> out_valid=0 and in_ready=1 immediately. A following full block emits only new data, with its first beat 1 cycle after its row 7.
- Zigzag, OUT_LANES=8: coefficient value = raster index (row r holds r*8..r*8+7), in_zz=1 -> beat0 = {0,1,8,16,9,2,3,10} with out_first=1; beat7 = {53,60,61,54,47,55,62,63} with out_last=1.
- Raster mode: same block, in_zz=0 -> beat b = {8b..8b+7}. Toggling in_zz during rows 1-7 has no effect.
- Ping-pong and backpressure: three blocks sent back-to-back, out_ready=0 throughout -> in_ready drops after the 16th row and the third block stalls. Releasing out_ready drains block 1 then block 2 intact. The third block's row 0 is accepted the cycle after block 1's last beat.
- Random out_ready (50%) over 20 blocks with mixed modes: scoreboard matches the ZZ/raster model, out_data is stable under stall, and no coefficient is lost or duplicated.
- OUT_LANES=1 and OUT_LANES=2 builds: 64 and 32 beats per block; the zigzag sequence matches the OUT_LANES=8 order; out_last appears on beat 63 and beat 31 respectively.
